// File: rtl/pio_input_poller_if.sv
`default_nettype none
// ============================================================================
// Module   : pio_input_poller_if
// Brief    : Avalon-MM read-only master/slave bundle for the PIO poller.
// Revision : 1.0 - initial release
// ============================================================================
interface pio_input_poller_if;
    logic [1:0]  m_address;
    logic        m_read;
    logic [31:0] m_readdata;

    modport master (
        output m_address,
        output m_read,
        input  m_readdata
    );

    modport slave (
        input  m_address,
        input  m_read,
        output m_readdata
    );
endinterface
`default_nettype wire

// File: rtl/pio_input_poller.sv
`default_nettype none
// ============================================================================
// Module   : pio_input_poller
// Brief    : Periodic Avalon-MM reader of an input PIO with poll-based debounce.
// Revision : 1.0 - initial release
// ============================================================================
module pio_input_poller #(
    parameter int WIDTH        = 4,
    parameter int POLL_DIV     = 1000,
    parameter int READ_LATENCY = 1,
    parameter int STABLE_POLLS = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    pio_input_poller_if.master   avm,
    input  logic [WIDTH-1:0]     clear_edges,
    output logic [WIDTH-1:0]     stable_value,
    output logic                 changed,
    output logic [WIDTH-1:0]     edge_capture
);

    localparam int                   c_TIMER_W   = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
    // READ is entered from the cycle where the timer reads POLL_DIV-2, so the
    // READ cycle itself is the POLL_DIV-1 step and the period stays POLL_DIV.
    localparam logic [c_TIMER_W-1:0] c_TIMER_PRE = c_TIMER_W'(POLL_DIV - 2);
    localparam logic [1:0]           c_LAT_LAST  = 2'(READ_LATENCY - 1);
    localparam logic [3:0]           c_STABLE    = 4'(STABLE_POLLS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [c_TIMER_W-1:0]   w_timer_nxt;
    logic [1:0]             r_lat;
    logic [1:0]             w_lat_nxt;
    logic                   w_sample;

    logic [WIDTH-1:0]       r_cand;
    logic [3:0]             r_count;
    logic [WIDTH-1:0]       w_s;
    logic [3:0]             w_cnt_new;
    logic                   w_accept;
    logic [WIDTH-1:0]       w_set;

    assign avm.m_address = 2'b00;
    assign avm.m_read    = (r_state == S_READ);

    generate
        if (WIDTH < 32) begin : g_unused_rdata
            logic w_unused_rdata;
            assign w_unused_rdata = ^avm.m_readdata[31:WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_lat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_lat   <= w_lat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_lat_nxt   = r_lat;
        w_sample    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!enable) begin
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                    if (r_timer == c_TIMER_PRE) begin
                        w_state_nxt = S_READ;
                    end
                end
            end
            S_READ: begin
                w_timer_nxt = '0;
                w_lat_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_timer_nxt = r_timer + 1'b1;
                if (r_lat == c_LAT_LAST) begin
                    w_sample    = 1'b1;
                    w_state_nxt = S_IDLE;
                    // Re-enabling right after a disabled read must start a fresh period.
                    if (!enable) begin
                        w_timer_nxt = '0;
                    end
                end else begin
                    w_lat_nxt = r_lat + 2'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = '0;
                w_lat_nxt   = '0;
            end
        endcase
    end

    assign w_s       = avm.m_readdata[WIDTH-1:0];
    assign w_cnt_new = (w_s != r_cand)      ? 4'd1 :
                       (r_count >= c_STABLE) ? c_STABLE : (r_count + 4'd1);
    assign w_accept  = w_sample && (w_cnt_new >= c_STABLE) && (w_s != stable_value);
    assign w_set     = w_accept ? (w_s ^ stable_value) : '0;

    // A set from an accept in the same cycle overrides a clear request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cand       <= '0;
            r_count      <= '0;
            stable_value <= '0;
            changed      <= 1'b0;
            edge_capture <= '0;
        end else begin
            changed      <= w_accept;
            edge_capture <= (edge_capture & ~clear_edges) | w_set;
            if (w_sample) begin
                r_cand  <= w_s;
                r_count <= w_cnt_new;
                if (w_accept) begin
                    stable_value <= w_s;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pio_input_poller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pio_input_poller
// Brief    : Directed self-checking bench for pio_input_poller (two configs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pio_input_poller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en_a, en_b;
    logic [3:0] pio_a, data_b;
    logic [3:0] clr_a, clr_b;
    logic [3:0] stable_a, edge_a, stable_b, edge_b;
    logic       changed_a, changed_b;

    int cyc       = 0;
    int checks    = 0;
    int errors    = 0;
    int rd_cnt_a  = 0;
    int rd_cnt_b  = 0;
    int chg_cnt_a = 0;
    int b2b       = 0;
    logic prev_rd_a = 1'b0;
    logic prev_rd_b = 1'b0;
    logic [2:0] rd_pipe_b = 3'b000;

    pio_input_poller_if avm_a ();
    pio_input_poller_if avm_b ();

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave A: data always valid on the bus, upper bits set to prove they are ignored.
    assign avm_a.m_readdata = {28'hFFF_FFFF, pio_a};

    // Slave B: valid data only three cycles after the read strobe, garbage otherwise.
    always @(posedge clk) rd_pipe_b <= {rd_pipe_b[1:0], avm_b.m_read};
    assign avm_b.m_readdata = rd_pipe_b[2] ? {28'hFFF_FFFF, data_b} : {28'hABC_DEF1, ~data_b};

    always @(negedge clk) begin
        if (avm_a.m_read) rd_cnt_a++;
        if (avm_b.m_read) rd_cnt_b++;
        if (avm_a.m_read && prev_rd_a) b2b++;
        if (avm_b.m_read && prev_rd_b) b2b++;
        prev_rd_a = avm_a.m_read;
        prev_rd_b = avm_b.m_read;
        if (changed_a) chg_cnt_a++;
    end

    pio_input_poller #(
        .WIDTH(4), .POLL_DIV(16), .READ_LATENCY(1), .STABLE_POLLS(3)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(en_a), .avm(avm_a.master),
        .clear_edges(clr_a), .stable_value(stable_a), .changed(changed_a),
        .edge_capture(edge_a)
    );

    pio_input_poller #(
        .WIDTH(4), .POLL_DIV(16), .READ_LATENCY(3), .STABLE_POLLS(1)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(en_b), .avm(avm_b.master),
        .clear_edges(clr_b), .stable_value(stable_b), .changed(changed_b),
        .edge_capture(edge_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_read(input int which, output int t);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < 64) begin
            @(negedge clk);
            n++;
            if ((which == 0) ? avm_a.m_read : avm_b.m_read) seen = 1'b1;
        end
        check("read_timeout", {31'd0, seen}, 32'd1);
        t = cyc;
    endtask

    task automatic go_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        int e, t, t1, t2, t3, snap;
        reset_n = 1'b0;
        en_a    = 1'b0;
        en_b    = 1'b0;
        pio_a   = 4'h5;
        data_b  = 4'h9;
        clr_a   = 4'h0;
        clr_b   = 4'h0;
        #1;
        check("rst_stable",  {28'd0, stable_a}, 32'h0);
        check("rst_changed", {31'd0, changed_a}, 32'h0);
        check("rst_edge",    {28'd0, edge_a}, 32'h0);
        check("rst_mread",   {31'd0, avm_a.m_read}, 32'h0);
        check("rst_addr",    {30'd0, avm_a.m_address}, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Disabled: no polling at all.
        repeat (5000) @(negedge clk);
        check("idle_reads",  rd_cnt_a, 0);
        check("idle_stable", {28'd0, stable_a}, 32'h0);
        check("idle_edge",   {28'd0, edge_a}, 32'h0);

        // Basic accept after three identical polls.
        en_a = 1'b1;
        e    = cyc;
        wait_read(0, t1);
        check("first_read_cycle", t1 - e, 15);
        wait_read(0, t2);
        check("poll_period", t2 - t1, 16);
        wait_read(0, t3);
        go_to(t3 + 1);
        check("pre_accept_stable", {28'd0, stable_a}, 32'h0);
        go_to(t3 + 2);
        check("accept_stable",  {28'd0, stable_a}, 32'h5);
        check("accept_changed", {31'd0, changed_a}, 32'h1);
        check("accept_edge",    {28'd0, edge_a}, 32'h5);
        go_to(t3 + 3);
        check("changed_one_cycle", {31'd0, changed_a}, 32'h0);
        check("changed_count1", chg_cnt_a, 1);

        // Single-poll glitch is rejected.
        pio_a = 4'h7;
        wait_read(0, t);
        go_to(t + 2);
        pio_a = 4'h5;
        wait_read(0, t);
        wait_read(0, t);
        wait_read(0, t);
        go_to(t + 3);
        check("glitch_stable", {28'd0, stable_a}, 32'h5);
        check("glitch_changed", chg_cnt_a, 1);
        check("glitch_edge", {28'd0, edge_a}, 32'h5);

        // Toggle bit0, with a full clear landing in the same cycle as the set.
        pio_a = 4'h4;
        wait_read(0, t);
        wait_read(0, t);
        wait_read(0, t);
        check("toggle_pre_stable", {28'd0, stable_a}, 32'h5);
        go_to(t + 1);
        clr_a = 4'hF;
        go_to(t + 2);
        clr_a = 4'h0;
        check("toggle_stable",  {28'd0, stable_a}, 32'h4);
        check("toggle_changed", {31'd0, changed_a}, 32'h1);
        check("set_beats_clear", {28'd0, edge_a}, 32'h1);
        go_to(t + 3);
        clr_a = 4'hF;
        go_to(t + 4);
        clr_a = 4'h0;
        check("clear_edge", {28'd0, edge_a}, 32'h0);

        // Saturated match count: further identical polls accept nothing.
        wait_read(0, t);
        wait_read(0, t);
        go_to(t + 3);
        check("saturate_changed", chg_cnt_a, 2);
        check("saturate_stable", {28'd0, stable_a}, 32'h4);

        // Asynchronous reset during WAIT.
        wait_read(0, t);
        go_to(t + 1);
        reset_n = 1'b0;
        #1;
        check("async_stable",  {28'd0, stable_a}, 32'h0);
        check("async_changed", {31'd0, changed_a}, 32'h0);
        check("async_mread",   {31'd0, avm_a.m_read}, 32'h0);
        repeat (2) @(negedge clk);
        pio_a   = 4'hA;
        reset_n = 1'b1;
        e       = cyc;
        wait_read(0, t);
        check("post_reset_read_cycle", t - e, 15);

        // Dropping enable during a read: that read finishes, none follow.
        en_a = 1'b0;
        go_to(t + 2);
        snap = rd_cnt_a;
        repeat (60) @(negedge clk);
        check("disable_no_reads", rd_cnt_a, snap);
        check("disable_stable", {28'd0, stable_a}, 32'h0);

        // Latency-3 slave with immediate acceptance.
        en_b = 1'b1;
        wait_read(1, t);
        go_to(t + 3);
        check("lat3_pre_stable", {28'd0, stable_b}, 32'h0);
        go_to(t + 4);
        check("lat3_stable",  {28'd0, stable_b}, 32'h9);
        check("lat3_changed", {31'd0, changed_b}, 32'h1);
        check("lat3_edge",    {28'd0, edge_b}, 32'h9);
        data_b = 4'h3;
        wait_read(1, t);
        go_to(t + 4);
        check("lat3_stable2", {28'd0, stable_b}, 32'h3);
        check("lat3_edge2",   {28'd0, edge_b}, 32'hB);

        check("no_back_to_back", b2b, 0);
        check("addr_b", {30'd0, avm_b.m_address}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pio_input_poller.md
# pio_input_poller

Avalon-MM master that periodically reads the input-PIO slave (data register at address 0) and debounces the sampled value across consecutive polls. It publishes a stable value, a one-cycle change strobe and sticky per-bit edge-capture flags to fabric logic, so switch or status inputs behind the PIO need no CPU polling. It sits between the Qsys PIO slave port and downstream control logic on the same clock domain.

## Interface
- WIDTH, 4: number of PIO input bits used, taken from m_readdata[WIDTH-1:0].
- POLL_DIV, 1000: cycles between successive read strobes; must be ≥ READ_LATENCY+2.
- READ_LATENCY, 1: fixed slave read latency in cycles; 1..4.
- STABLE_POLLS, 3: consecutive identical samples needed to accept a value; 1..15.

- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  polling enable; level.
- m_address  out  2  Avalon address; constant 0.
- m_read  out  1  Avalon read strobe; one-cycle pulse per poll.
- m_readdata  in  32  Avalon read data; bits above WIDTH-1 ignored.
- clear_edges  in  WIDTH  write-1-to-clear for edge_capture; sampled every cycle.
- stable_value  out  WIDTH  last debounced value.
- changed  out  1  one-cycle pulse when stable_value updates.
- edge_capture  out  WIDTH  sticky flags: bit set when that stable_value bit toggles.

## Operation
- Reset values: m_read 0, m_address 0, stable_value 0, changed 0, edge_capture 0, FSM IDLE, poll timer 0, candidate 0, match count 0.
- FSM states:
  - IDLE: timer counts up while enable=1. When it reaches POLL_DIV-1 → READ, timer←0. While enable=0 the timer holds at 0.
  - READ: m_read=1 for exactly this cycle → WAIT.
  - WAIT: stays READ_LATENCY cycles, counting cycles since READ. At the end of the READ_LATENCY-th cycle, sample s = m_readdata[WIDTH-1:0] → IDLE.
- The timer keeps running during READ and WAIT, so the read period is exactly POLL_DIV cycles.
- Dropping enable mid-read completes the current READ/WAIT/sample, then holds in IDLE.
- Debounce on each sample s:
  - If s == candidate, match count increments, saturating at STABLE_POLLS.
  - Otherwise candidate←s and match count←1.
  - Accept when the new match count ≥ STABLE_POLLS and candidate(new) ≠ stable_value. On accept: stable_value←candidate, changed=1 for one cycle, edge_capture |= candidate ^ old stable_value.
  - STABLE_POLLS=1 accepts any differing sample immediately.
- edge_capture clear: bits with clear_edges=1 clear in the next cycle. If set and clear hit the same bit in the same cycle, set wins.
- Reset mid-operation: every register returns to its reset value immediately (asynchronous). Any in-flight read is abandoned and its data is never sampled.

## Timing
- Define READ cycle t: m_read=1 during t.
  - Sample registered at the clock edge ending cycle t+READ_LATENCY.
  - stable_value, changed and edge_capture update at that same edge, so they are visible in cycle t+READ_LATENCY+1.
  - changed lasts 1 cycle.
- First read after enable rises at cycle e: m_read high in cycle e+POLL_DIV-1.
- Worst-case acceptance latency after an input settles: STABLE_POLLS×POLL_DIV + READ_LATENCY + 1 cycles.
- m_read is never asserted in two consecutive cycles. m_address never changes.

## Test plan
- Reset/idle: reset_n low then high, enable=0 for 5000 cycles → m_read never asserted; all outputs 0.
- Basic accept: POLL_DIV=16, READ_LATENCY=1, STABLE_POLLS=3. Slave model drives 0x5 from the start; enable=1 → m_read pulses every 16 cycles. After the 3rd sample, stable_value=0x5, changed pulses once, edge_capture=0x5.
- Glitch reject: stable 0x5; slave returns 0x7 for one poll, then 0x5 → no changed pulse; stable_value stays 0x5; edge_capture unchanged.
- Toggle and clear: stable 0x5 → 0x4 after 3 polls gives edge_capture |= 0x1. Pulse clear_edges=0xF in the same cycle as the set → bit0 stays 1, other bits clear. Next clear → edge_capture=0.
- Latency sweep: READ_LATENCY=3; slave model returns data 3 cycles after m_read, with garbage on the cycles in between → sampled value equals the latency-3 data only.
- Async reset mid-WAIT: assert reset_n during the WAIT cycle → outputs 0 immediately. After release with enable=1, the next m_read occurs POLL_DIV-1 cycles later.
